div_r32i: RTL
=============

DIV_R32I -- requirements
Module: div_r32i

Interface
REQ-001 Parameter dataW, default 32: operand and result width.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe, sampled only while ready=1.
REQ-005 ALUCode  input  5  operation select; DIV, DIVU, REM, REMU codes only.
REQ-006 A  input  dataW  dividend, captured on accept.
REQ-007 B  input  dataW  divisor, captured on accept.
REQ-008 ready  output  1  high only in IDLE; unit can accept a request.
REQ-009 valid  output  1  one-cycle pulse marking result as new.
REQ-010 result  output  dataW  quotient or remainder; held until the next valid.

Function
REQ-011 Accept SHALL occur on the rising edge where start=1, ready=1 and ALUCode is one of DIV/DIVU/REM/REMU; A, B and ALUCode SHALL be registered on that edge.
REQ-012 start with any other ALUCode, or while ready=0, SHALL be ignored with no state change.
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; transitions: IDLE->CALC on normal accept, IDLE->DONE on special-case accept, CALC->FIX after 32 iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle on operand magnitudes (signed ops) or raw operands (unsigned ops), 32 cycles total.
REQ-015 FIX SHALL negate the quotient when operand signs differ (DIV), and SHALL give the remainder the sign of the dividend (REM).
REQ-016 valid SHALL be high exactly in the DONE cycle; for a normal op this is the cycle after the 34th rising edge counted from the accept edge (accept edge = edge 0, so DONE is entered on edge 33 and exits on edge 34). Equivalently, valid is high in the cycle following edge 33.
REQ-017 result SHALL update on the edge entering DONE and SHALL be unchanged at all other times.
REQ-018 Divide-by-zero (B=0) SHALL take the special path: DIV/DIVU result 0xFFFFFFFF, REM/REMU result = A; valid in the cycle after the accept edge.
REQ-019 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF) SHALL take the special path: DIV result 0x80000000, REM result 0.
REQ-020 start asserted during DONE SHALL be ignored; the earliest next accept is on the edge after DONE.
REQ-021 Arithmetic SHALL be two's complement at dataW bits; magnitude of 0x80000000 SHALL be handled as unsigned 0x80000000 without overflow.

Reset
REQ-022 While reset=0: state=IDLE, ready=1, valid=0, result=0, internal registers cleared, independent of clock.
REQ-023 Reset asserted mid-operation SHALL abort the operation; no valid pulse for it SHALL ever appear.

Structure
REQ-024 DIV, DIVU, REM, REMU 5-bit codes SHALL be added to the shared ALU-code definitions used by aluR32I, with no collision against existing codes.
REQ-025 The state enum SHALL live in the same shared package.
REQ-026 One combinational sub-module div_step_r32i (single restoring iteration: shift, trial subtract, select) is natural; the iteration counter and FSM stay in div_r32i.

Verification
REQ-027 DIVU A=100 B=7 -> result 14, valid in the cycle after edge 33; REMU same operands -> 2.
REQ-028 DIV A=-100 B=7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; DIV A=100 B=-7 -> 0xFFFFFFF2, REM -> 2.
REQ-029 DIV A=9 B=0 -> 0xFFFFFFFF; REMU A=9 B=0 -> 9; valid in the cycle after accept.
REQ-030 DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU A=0xFFFFFFFF B=2 -> 0x7FFFFFFF, REMU -> 1.
REQ-031 Assert reset after the 10th CALC cycle -> valid never pulses, ready=1 after release; a following DIVU 100/7 returns 14 with normal latency.
REQ-032 Pulse start with ALUCode=ADD, and separately during CALC and DONE -> no accept, ready and result unchanged, only one valid pulse per accepted request.

Source files
------------

// File: rtl/div_r32i_pkg.sv
// div_r32i_pkg: shared ALU operation codes and divider state encoding
package div_r32i_pkg;
  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_SLL  = 5'h02;
  localparam logic [4:0] ALU_SLT  = 5'h03;
  localparam logic [4:0] ALU_SLTU = 5'h04;
  localparam logic [4:0] ALU_XOR  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_OR   = 5'h08;
  localparam logic [4:0] ALU_AND  = 5'h09;
  localparam logic [4:0] ALU_LUI  = 5'h0a;
  localparam logic [4:0] ALU_DIV  = 5'h10;
  localparam logic [4:0] ALU_DIVU = 5'h11;
  localparam logic [4:0] ALU_REM  = 5'h12;
  localparam logic [4:0] ALU_REMU = 5'h13;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  function automatic logic is_div_op(input logic [4:0] c);
    return c == ALU_DIV || c == ALU_DIVU || c == ALU_REM || c == ALU_REMU;
  endfunction
endpackage

// File: rtl/div_step_r32i.sv
// div_step_r32i: one restoring division iteration (shift, trial subtract, select)
module div_step_r32i #(
  parameter int dataW = 32
) (
  input  logic [dataW-1:0] rem,
  input  logic [dataW-1:0] quo,
  input  logic [dataW-1:0] den,
  output logic [dataW-1:0] rem_n,
  output logic [dataW-1:0] quo_n
);
  logic [dataW:0] shifted, diff;
  always_comb begin
    shifted = {rem, quo[dataW-1]};
    diff = shifted - {1'b0, den};
    rem_n = diff[dataW] ? shifted[dataW-1:0] : diff[dataW-1:0];
    quo_n = {quo[dataW-2:0], ~diff[dataW]};
  end
endmodule

// File: rtl/div_r32i.sv
// div_r32i: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_r32i
  import div_r32i_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUCode,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  output logic             ready,
  output logic             valid,
  output logic [dataW-1:0] result
);
  localparam int CW = $clog2(dataW);
  div_state_t state, state_n;
  logic [dataW-1:0] rem, quo, den, rem_n, quo_n, mag_a, mag_b, spec_res, fix_res;
  logic [CW-1:0] cnt;
  logic neg, sel_q, accept, sgn, q_op, b_zero, ovf, special, last;
  div_step_r32i #(.dataW(dataW)) u_step (
    .rem(rem), .quo(quo), .den(den), .rem_n(rem_n), .quo_n(quo_n)
  );
  assign ready = state == IDLE;
  assign valid = state == DONE;
  always_comb begin
    sgn = ALUCode == ALU_DIV || ALUCode == ALU_REM;
    q_op = ALUCode == ALU_DIV || ALUCode == ALU_DIVU;
    mag_a = sgn && A[dataW-1] ? -A : A;
    mag_b = sgn && B[dataW-1] ? -B : B;
    b_zero = B == '0;
    ovf = sgn && A == {1'b1, {(dataW-1){1'b0}}} && B == '1;
    special = b_zero || ovf;
    // signed overflow quotient equals the dividend itself (most negative value)
    spec_res = b_zero ? (q_op ? '1 : A) : (q_op ? A : '0);
    accept = start && state == IDLE && is_div_op(ALUCode);
    last = cnt == CW'(dataW - 1);
    fix_res = sel_q ? (neg ? -quo : quo) : (neg ? -rem : rem);
    state_n = state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE) :
              state == CALC ? (last ? FIX : CALC) :
              state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem <= '0;
      quo <= '0;
      den <= '0;
      cnt <= '0;
      neg <= 1'b0;
      sel_q <= 1'b0;
      result <= '0;
    end else if (accept) begin
      rem <= '0;
      quo <= mag_a;
      den <= mag_b;
      cnt <= '0;
      sel_q <= q_op;
      neg <= sgn && (q_op ? A[dataW-1] ^ B[dataW-1] : A[dataW-1]);
      if (special) result <= spec_res;
    end else if (state == CALC) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      result <= fix_res;
    end
  end
endmodule
